// File: rtl/debouncer_bank.sv
// Bank of independent button/switch debouncers with edge and long-press pulses.
//
// Each channel synchronises its raw input through two flops, then accepts a new
// level only after it has been stable for DB_CYCLES synchronised cycles. Accepted
// transitions produce one-cycle rise/fall pulses aligned with the first cycle of
// the new clean level. A hold counter tracks how long clean has been high and
// emits a single long_press pulse once it reaches HOLD_CYCLES.
//
// Ports:
//   clk        - sole clock, rising edge
//   sys_reset  - asynchronous active-low reset
//   noisy      - raw asynchronous input levels, bit i = channel i
//   clean      - debounced level per channel
//   rise_pulse - one-cycle pulse on each accepted 0->1 transition
//   fall_pulse - one-cycle pulse on each accepted 1->0 transition
//   long_press - one-cycle pulse when clean has been high HOLD_CYCLES cycles
module debouncer_bank #(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned DB_CYCLES   = 16,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                sys_reset,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] long_press
);

  localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch

    logic              sync1;
    logic              sync2;
    logic [DB_W-1:0]   db_cnt;
    logic [DB_W-1:0]   db_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic              clean_q;
    logic              clean_nxt;
    logic              rise_q;
    logic              rise_nxt;
    logic              fall_q;
    logic              fall_nxt;
    logic              long_q;
    logic              long_nxt;
    logic              accept;

    // Debounce, edge-pulse and hold-counter next-state logic.
    always_comb begin
      accept       = 1'b0;
      db_cnt_nxt   = '0;
      clean_nxt    = clean_q;
      rise_nxt     = 1'b0;
      fall_nxt     = 1'b0;
      hold_cnt_nxt = '0;
      long_nxt     = 1'b0;

      // Count only while the synchronised level disagrees with clean; any
      // agreeing cycle leaves db_cnt_nxt at its zero default.
      if (sync2 != clean_q) begin
        if (db_cnt == DB_LAST) begin
          accept    = 1'b1;
          clean_nxt = sync2;
          rise_nxt  = sync2;
          fall_nxt  = ~sync2;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end

      // A fall accepted on this edge ends the press, so it neither advances
      // the hold count nor lets long_press fire alongside fall_pulse.
      if (clean_q && !accept) begin
        hold_cnt_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
        long_nxt     = (hold_cnt == HOLD_LAST);
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge sys_reset) begin
      if (!sys_reset) begin
        sync1    <= 1'b0;
        sync2    <= 1'b0;
        db_cnt   <= '0;
        hold_cnt <= '0;
        clean_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        long_q   <= 1'b0;
      end else begin
        sync1    <= noisy[i];
        sync2    <= sync1;
        db_cnt   <= db_cnt_nxt;
        hold_cnt <= hold_cnt_nxt;
        clean_q  <= clean_nxt;
        rise_q   <= rise_nxt;
        fall_q   <= fall_nxt;
        long_q   <= long_nxt;
      end
    end

    assign clean[i]      = clean_q;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
    assign long_press[i] = long_q;

  end : g_ch

endmodule
